// File: rtl/sram_fifo_fwft_adapter.sv
// First-word-fall-through adapter for a BRAM FIFO with one-cycle registered read data.
// Keeps reads in flight and parks returned words in a 2-entry buffer in front of the consumer.
module sram_fifo_fwft_adapter #(
    parameter int DATA_WIDTH = 32,
    parameter int BUF_DEPTH  = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  fifo_ready_i,
    input  logic                  fifo_empty_i,
    output logic                  fifo_rden_o,
    input  logic [DATA_WIDTH-1:0] fifo_data_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [1:0]            count_o
);

    if (BUF_DEPTH != 2) begin : g_bad_depth
        $error("sram_fifo_fwft_adapter: BUF_DEPTH must be 2");
    end

    logic [1:0]            occ_q;
    logic                  inflight_q;
    logic [DATA_WIDTH-1:0] buf_q [2];

    logic       pop;
    logic       capture;
    logic       wr_idx;
    logic [2:0] pending;

    // Handshake: a word transfers on every rising edge where valid_o and ready_i are both high;
    // valid_o/data_o never change while valid_o is high and ready_i is low (except on flush/reset).
    assign valid_o = (occ_q != 2'd0);
    assign data_o  = buf_q[0];
    assign count_o = occ_q;
    assign pop     = valid_o & ready_i;
    assign capture = inflight_q;

    // A capture only happens with occ_q <= 1, so the write slot (occ_q - pop) is 0 or 1.
    assign wr_idx  = (occ_q == 2'd1) & ~pop;

    // Words that will sit in the buffer after this edge if no new read is issued.
    assign pending = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};

    assign fifo_rden_o = fifo_ready_i & ~fifo_empty_i & ~flush_i & (pending < 3'd2);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            buf_q[0]   <= '0;
            buf_q[1]   <= '0;
        end else if (flush_i) begin
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
        end else begin
            if (pop) begin
                buf_q[0] <= buf_q[1];
            end
            // Issued after the shift so a same-cycle capture into slot 0 wins.
            if (capture) begin
                buf_q[wr_idx] <= fifo_data_i;
            end
            occ_q      <= occ_q + {1'b0, capture} - {1'b0, pop};
            inflight_q <= fifo_rden_o;
        end
    end

    a_no_overflow : assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        ({1'b0, occ_q} + {2'b00, inflight_q}) <= 3'd2
    ) else $error("sram_fifo_fwft_adapter: occupancy plus in-flight read exceeds 2");

endmodule

// File: tb/tb_sram_fifo_fwft_adapter.sv
// Bench for sram_fifo_fwft_adapter: a queue-based BRAM FIFO model with one-cycle read latency
// feeds the DUT, and a scoreboard of words read but not yet delivered predicts every output.
module tb_sram_fifo_fwft_adapter;

    localparam int DW = 32;

    logic          clk_i;
    logic          rst_ni;
    logic          flush_i;
    logic          fifo_ready_i;
    logic          fifo_empty_i;
    logic          fifo_rden_o;
    logic [DW-1:0] fifo_data_i;
    logic [DW-1:0] data_o;
    logic          valid_o;
    logic          ready_i;
    logic [1:0]    count_o;

    sram_fifo_fwft_adapter #(
        .DATA_WIDTH(DW),
        .BUF_DEPTH (2)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .flush_i     (flush_i),
        .fifo_ready_i(fifo_ready_i),
        .fifo_empty_i(fifo_empty_i),
        .fifo_rden_o (fifo_rden_o),
        .fifo_data_i (fifo_data_i),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .count_o     (count_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] ret_word;
    int            m_infl;
    int            n_deliv;
    int            total;
    int            bad;

    logic          obs_rd;
    logic          obs_valid;
    logic [DW-1:0] obs_data;
    logic [1:0]    obs_count;

    // ---------------- driver / scoreboard ----------------

    task automatic push_word(input logic [DW-1:0] w);
        fifo_q.push_back(w);
        fifo_empty_i = 1'b0;
    endtask

    // Scores the current cycle at the falling edge, then advances to just after the next rising edge
    // where the FIFO model returns the word read in the cycle just ended.
    task automatic cycle();
        int exp_rd;
        int m_pop;
        @(negedge clk_i);
        obs_rd    = fifo_rden_o;
        obs_valid = valid_o;
        obs_data  = data_o;
        obs_count = count_o;
        if (rst_ni) begin
            m_pop  = (exp_q.size() != 0 && ready_i) ? 1 : 0;
            exp_rd = (fifo_ready_i && !fifo_empty_i && !flush_i &&
                      (exp_q.size() + m_infl - m_pop) < 2) ? 1 : 0;
            total++;
            if (count_o !== 2'(exp_q.size())) begin
                bad++;
                $display("FAIL sb_count: got %0d expected %0d", count_o, exp_q.size());
            end
            total++;
            if (valid_o !== (exp_q.size() != 0)) begin
                bad++;
                $display("FAIL sb_valid: got %0b expected %0b", valid_o, exp_q.size() != 0);
            end
            if (exp_q.size() != 0) begin
                total++;
                if (data_o !== exp_q[0]) begin
                    bad++;
                    $display("FAIL sb_data: got %08h expected %08h", data_o, exp_q[0]);
                end
            end
            total++;
            if (fifo_rden_o !== exp_rd[0]) begin
                bad++;
                $display("FAIL sb_rden: got %0b expected %0d (empty=%0b)", fifo_rden_o, exp_rd, fifo_empty_i);
            end
            total++;
            if (exp_q.size() + m_infl > 2) begin
                bad++;
                $display("FAIL sb_occupancy: got %0d expected at most 2", exp_q.size() + m_infl);
            end
            if (flush_i) begin
                exp_q.delete();
            end else begin
                if (m_pop == 1) begin
                    void'(exp_q.pop_front());
                    n_deliv++;
                end
                if (m_infl != 0) exp_q.push_back(ret_word);
            end
            m_infl = (fifo_rden_o === 1'b1 && fifo_q.size() != 0) ? 1 : 0;
        end else begin
            m_infl = 0;
        end
        @(posedge clk_i);
        #1;
        if (m_infl != 0) begin
            ret_word    = fifo_q.pop_front();
            fifo_data_i = ret_word;
        end else begin
            fifo_data_i = $urandom();
        end
        fifo_empty_i = (fifo_q.size() == 0);
    endtask

    task automatic apply_reset();
        rst_ni       = 1'b0;
        fifo_q.delete();
        exp_q.delete();
        m_infl       = 0;
        fifo_empty_i = 1'b1;
        fifo_ready_i = 1'b0;
        ready_i      = 1'b0;
        flush_i      = 1'b0;
        #1;
        total++;
        if (valid_o !== 1'b0 || count_o !== 2'd0 || data_o !== '0 || fifo_rden_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs: got valid=%0b count=%0d data=%08h rden=%0b expected 0 0 0 0",
                     valid_o, count_o, data_o, fifo_rden_o);
        end
        cycle();
        cycle();
        rst_ni = 1'b1;
    endtask

    task automatic drain();
        int done;
        done         = 0;
        ready_i      = 1'b1;
        flush_i      = 1'b0;
        fifo_ready_i = 1'b1;
        for (int i = 0; i < 100 && done == 0; i++) begin
            cycle();
            if (fifo_q.size() == 0 && exp_q.size() == 0 && m_infl == 0) done = 1;
        end
        total++;
        if (done == 0) begin
            bad++;
            $display("FAIL drain_timeout: got %0d words left expected 0", exp_q.size() + fifo_q.size());
        end
    endtask

    // ---------------- tests ----------------

    task automatic test_reset();
        rst_ni       = 1'b1;
        flush_i      = 1'b0;
        fifo_ready_i = 1'b0;
        fifo_empty_i = 1'b1;
        ready_i      = 1'b0;
        fifo_data_i  = '0;
        #2;
        apply_reset();
        cycle();
        total++;
        if (obs_valid !== 1'b0 || obs_count !== 2'd0) begin
            bad++;
            $display("FAIL reset_idle: got valid=%0b count=%0d expected 0 0", obs_valid, obs_count);
        end
    endtask

    task automatic test_latency();
        logic [DW-1:0] a [4];
        for (int i = 0; i < 4; i++) a[i] = $urandom();
        ready_i      = 1'b1;
        fifo_ready_i = 1'b1;
        cycle();
        for (int i = 0; i < 4; i++) push_word(a[i]);
        for (int k = 0; k < 8; k++) begin
            cycle();
            total++;
            if (obs_rd !== (k < 4)) begin
                bad++;
                $display("FAIL latency_rden k=%0d: got %0b expected %0b", k, obs_rd, k < 4);
            end
            total++;
            if (obs_valid !== (k >= 2 && k <= 5)) begin
                bad++;
                $display("FAIL latency_valid k=%0d: got %0b expected %0b", k, obs_valid, k >= 2 && k <= 5);
            end
            if (k >= 2 && k <= 5) begin
                total++;
                if (obs_data !== a[k-2]) begin
                    bad++;
                    $display("FAIL latency_data k=%0d: got %08h expected %08h", k, obs_data, a[k-2]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] w [5];
        int pulses;
        drain();
        ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            w[i] = $urandom();
            push_word(w[i]);
        end
        pulses = 0;
        for (int k = 0; k < 8; k++) begin
            cycle();
            if (obs_rd) pulses++;
            if (k >= 2) begin
                total++;
                if (obs_data !== w[0]) begin
                    bad++;
                    $display("FAIL bp_hold k=%0d: got %08h expected %08h", k, obs_data, w[0]);
                end
            end
        end
        total++;
        if (pulses != 2) begin
            bad++;
            $display("FAIL bp_rden_pulses: got %0d expected 2", pulses);
        end
        total++;
        if (obs_count !== 2'd2) begin
            bad++;
            $display("FAIL bp_count: got %0d expected 2", obs_count);
        end
        ready_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cycle();
            total++;
            if (obs_valid !== 1'b1 || obs_data !== w[k]) begin
                bad++;
                $display("FAIL bp_restart k=%0d: got valid=%0b data=%08h expected 1 %08h",
                         k, obs_valid, obs_data, w[k]);
            end
        end
    endtask

    task automatic test_random();
        int pushed;
        int start;
        int n;
        drain();
        pushed = 0;
        start  = n_deliv;
        for (int c = 0; c < 20000 && (n_deliv - start) < 1000; c++) begin
            ready_i      = ($urandom_range(0, 3) != 0);
            fifo_ready_i = ($urandom_range(0, 15) != 0);
            if (pushed < 1000 && $urandom_range(0, 2) == 0) begin
                n = $urandom_range(1, 3);
                for (int j = 0; j < n && pushed < 1000; j++) begin
                    push_word($urandom());
                    pushed++;
                end
            end
            cycle();
        end
        total++;
        if ((n_deliv - start) != 1000) begin
            bad++;
            $display("FAIL random_delivered: got %0d expected 1000", n_deliv - start);
        end
    endtask

    task automatic test_flush();
        logic [DW-1:0] w [4];
        int seen;
        drain();
        ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            w[i] = $urandom();
            push_word(w[i]);
        end
        cycle();
        cycle();
        total++;
        if (obs_rd !== 1'b1) begin
            bad++;
            $display("FAIL flush_setup_rden: got %0b expected 1", obs_rd);
        end
        flush_i = 1'b1;
        cycle();
        total++;
        if (obs_count !== 2'd1 || obs_rd !== 1'b0) begin
            bad++;
            $display("FAIL flush_cycle: got count=%0d rden=%0b expected 1 0", obs_count, obs_rd);
        end
        flush_i = 1'b0;
        ready_i = 1'b1;
        cycle();
        total++;
        if (obs_count !== 2'd0 || obs_valid !== 1'b0) begin
            bad++;
            $display("FAIL flush_after: got count=%0d valid=%0b expected 0 0", obs_count, obs_valid);
        end
        seen = 0;
        for (int k = 0; k < 10 && seen == 0; k++) begin
            cycle();
            if (obs_valid) begin
                seen = 1;
                total++;
                if (obs_data !== w[2]) begin
                    bad++;
                    $display("FAIL flush_next_word: got %08h expected %08h", obs_data, w[2]);
                end
            end
        end
        total++;
        if (seen == 0) begin
            bad++;
            $display("FAIL flush_no_word: got none expected %08h", w[2]);
        end
        drain();
    endtask

    task automatic test_fifo_ready();
        apply_reset();
        ready_i = 1'b1;
        for (int i = 0; i < 3; i++) push_word($urandom());
        for (int k = 0; k < 16; k++) begin
            cycle();
            total++;
            if (obs_rd !== 1'b0) begin
                bad++;
                $display("FAIL fready_low k=%0d: got rden=%0b expected 0", k, obs_rd);
            end
        end
        fifo_ready_i = 1'b1;
        cycle();
        total++;
        if (obs_rd !== 1'b1) begin
            bad++;
            $display("FAIL fready_rise: got rden=%0b expected 1", obs_rd);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        drain();
        ready_i = 1'b0;
        for (int i = 0; i < 4; i++) push_word($urandom());
        cycle();
        cycle();
        cycle();
        total++;
        if (obs_count !== 2'd1) begin
            bad++;
            $display("FAIL rstmid_setup: got count=%0d expected 1", obs_count);
        end
        cycle();
        total++;
        if (obs_count !== 2'd2) begin
            bad++;
            $display("FAIL rstmid_full: got count=%0d expected 2", obs_count);
        end
        #2;
        apply_reset();
        ready_i      = 1'b1;
        fifo_ready_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cycle();
            total++;
            if (obs_valid !== 1'b0 || obs_count !== 2'd0) begin
                bad++;
                $display("FAIL rstmid_after k=%0d: got valid=%0b count=%0d expected 0 0",
                         k, obs_valid, obs_count);
            end
        end
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        n_deliv = 0;
        m_infl  = 0;
        test_reset();
        test_latency();
        test_backpressure();
        test_random();
        test_flush();
        test_fifo_ready();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
